// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback arbiter.
// Holds the default datapath/address widths, the request record stored in
// the LSU FIFO, and the arbitration priority encoding.
package wb_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } wb_req_t;

    // Which source owns the write port this cycle.
    typedef enum logic {
        PIPE_PRI = 1'b0,
        LSU_PRI  = 1'b1
    } wb_pri_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; registered pointers and count, no bypass.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full_o/empty_o.
// Ports: clk/rst, push_i+push_dat_i, pop_i+pop_dat_o (head), full_o, empty_o, count_o.
module wb_fifo
    import wb_pkg::*;
#(
    parameter type T     = wb_req_t,
    parameter int  DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  T                         push_dat_i,
    input  logic                     pop_i,
    output T                         pop_dat_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count_q gates everything read out of it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between pipeline results and buffered LSU loads.
// Latency: pipe result on rf_* 1 cycle after fire; LSU result at least 2 cycles after fire.
// Backpressure: pipe_ready drops when the LSU FIFO is full or its head is starving; lsu_ready drops when full.
// Ports: clk/rst; pipe_valid/ready/rd/data; lsu_valid/ready/rd/data; registered rf_we/waddr/wdata; lsu_count.
module wb_port_arbiter #(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int RADDR_W    = wb_pkg::RADDR_W,
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pipe_valid,
    output logic                         pipe_ready,
    input  logic [RADDR_W-1:0]           pipe_rd,
    input  logic [XLEN-1:0]              pipe_data,
    input  logic                         lsu_valid,
    output logic                         lsu_ready,
    input  logic [RADDR_W-1:0]           lsu_rd,
    input  logic [XLEN-1:0]              lsu_data,
    output logic                         rf_we,
    output logic [RADDR_W-1:0]           rf_waddr,
    output logic [XLEN-1:0]              rf_wdata,
    output logic [$clog2(LSU_DEPTH):0]   lsu_count
);
    import wb_pkg::*;

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic [RADDR_W-1:0] rd;
        logic [XLEN-1:0]    data;
    } req_t;

    req_t               lsu_push_dat, lsu_head;
    logic               fifo_full, fifo_empty;
    logic               lsu_push, lsu_grant, pipe_fire, starve;
    wb_pri_e            pri;
    logic [SW-1:0]      starve_cnt_q, starve_cnt_d;
    logic               rf_we_q, rf_we_d;
    logic [RADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]    rf_wdata_q, rf_wdata_d;

    assign lsu_push_dat = '{rd: lsu_rd, data: lsu_data};
    assign lsu_push     = lsu_valid && lsu_ready;

    wb_fifo #(
        .T     (req_t),
        .DEPTH (LSU_DEPTH)
    ) u_lsu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (lsu_push),
        .push_dat_i (lsu_push_dat),
        .pop_i      (lsu_grant),
        .pop_dat_o  (lsu_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (lsu_count)
    );

    always_comb begin
        starve       = 1'b0;
        pri          = PIPE_PRI;
        pipe_ready   = 1'b0;
        lsu_ready    = 1'b0;
        pipe_fire    = 1'b0;
        lsu_grant    = 1'b0;
        starve_cnt_d = starve_cnt_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;

        // Priority is decided from registered state only, so neither ready
        // depends on a same-cycle valid.
        starve     = !fifo_empty && (starve_cnt_q >= SW'(STARVE_MAX));
        pri        = (fifo_full || starve) ? LSU_PRI : PIPE_PRI;
        pipe_ready = (pri == PIPE_PRI);
        lsu_ready  = !fifo_full;
        pipe_fire  = pipe_valid && pipe_ready;
        // The LSU head takes any cycle the pipe does not use.
        lsu_grant  = !fifo_empty && !pipe_fire;

        if (fifo_empty || lsu_grant) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < SW'(STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end

        // x0 writes complete the handshake but never assert the enable.
        if (pipe_fire) begin
            rf_we_d    = (pipe_rd != '0);
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_data;
        end else if (lsu_grant) begin
            rf_we_d    = (lsu_head.rd != '0);
            rf_waddr_d = lsu_head.rd;
            rf_wdata_d = lsu_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios then random traffic,
// checked against a queue-based reference model via an expected-output scoreboard.
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid, pipe_ready;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  lsu_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .XLEN       (32),
        .RADDR_W    (5),
        .LSU_DEPTH  (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_ready (pipe_ready),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_rd     (lsu_rd),
        .lsu_data   (lsu_data),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .lsu_count  (lsu_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    exp_t exp_q[$];

    // Reference model state: buffered loads in arrival order, how long the
    // oldest one has been passed over, and the last value on the write port.
    ent_t        mq[$];
    int          denied = 0;
    logic [4:0]  last_a = '0;
    logic [31:0] last_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, check the readies, and queue the expected
    // write-port value for the following cycle.
    task automatic cyc(input bit r, input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        int   cnt;
        bit   full, stv, epr, granted;
        ent_t ent;
        exp_t e;
        @(negedge clk);
        rst        = r;
        pipe_valid = pv;
        pipe_rd    = prd;
        pipe_data  = pd;
        lsu_valid  = lv;
        lsu_rd     = lrd;
        lsu_data   = ld;
        #1;
        cnt     = mq.size();
        full    = (cnt == DEPTH);
        stv     = (cnt > 0) && (denied >= SMAX);
        epr     = !(full || stv);
        granted = 1'b0;
        if (!r) begin
            chk("pipe_ready", 64'(pipe_ready), 64'(epr));
            chk("lsu_ready",  64'(lsu_ready),  64'(!full));
            chk("lsu_count",  64'(lsu_count),  64'(cnt));
        end
        if (r) begin
            mq.delete();
            denied = 0;
            last_a = '0;
            last_d = '0;
            e = '{we: 1'b0, a: 5'd0, d: 32'd0};
        end else begin
            if (pv && epr) begin
                e = '{we: (prd != 0), a: prd, d: pd};
            end else if (cnt > 0) begin
                ent = mq.pop_front();
                granted = 1'b1;
                e = '{we: (ent.rd != 0), a: ent.rd, d: ent.d};
            end else begin
                e = '{we: 1'b0, a: last_a, d: last_d};
            end
            last_a = e.a;
            last_d = e.d;
            if (cnt == 0 || granted) denied = 0;
            else if (denied < SMAX)  denied = denied + 1;
            if (lv && !full) mq.push_back('{rd: lrd, d: ld});
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    // Monitor: compare the registered write port against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rf_we",    64'(rf_we),    64'(e.we));
                chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
                chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
            end
        end
    end

    initial begin
        int wait_cnt;
        int pprob, lprob;
        bit r, pv, lv;
        rst = 1'b1; pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;

        cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(2);

        // pipe only
        cyc(0, 1, 5'd3, 32'h1, 0, 5'd0, 32'd0);
        idle(1);
        // x0 suppression
        cyc(0, 1, 5'd0, 32'hFFFF, 0, 5'd0, 32'd0);
        idle(1);
        // lsu only
        cyc(0, 0, 5'd0, 32'd0, 1, 5'd5, 32'h10);
        idle(3);
        // starvation: one load vs a continuous pipe stream
        cyc(0, 1, 5'd7, 32'h700, 1, 5'd11, 32'hAA);
        for (int i = 0; i < 8; i++) cyc(0, 1, 5'd7, 32'h701 + i, 0, 5'd0, 32'd0);
        idle(2);
        // full FIFO, drains in order
        cyc(0, 1, 5'd7, 32'h800, 1, 5'd8, 32'h88);
        cyc(0, 1, 5'd7, 32'h801, 1, 5'd9, 32'h99);
        for (int i = 0; i < 5; i++) cyc(0, 1, 5'd7, 32'h802 + i, 1, 5'd10, 32'hA0 + i);
        idle(3);
        // reset mid-operation with two buffered loads
        cyc(0, 1, 5'd7, 32'h900, 1, 5'd12, 32'hC0);
        cyc(0, 1, 5'd7, 32'h901, 1, 5'd13, 32'hC1);
        cyc(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        idle(4);

        // random traffic with varying load per phase
        for (int ph = 0; ph < 10; ph++) begin
            pprob = $urandom_range(10, 95);
            lprob = $urandom_range(5, 80);
            for (int i = 0; i < 250; i++) begin
                r  = ($urandom_range(0, 199) == 0);
                pv = !r && ($urandom_range(0, 99) < pprob);
                lv = !r && ($urandom_range(0, 99) < lprob);
                cyc(r, pv, 5'($urandom_range(0, 31)), $urandom,
                       lv, 5'($urandom_range(0, 31)), $urandom);
            end
        end
        idle(8);

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected writes never observed, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
